// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
//   uart_state_t   - transmitter FSM states
//   PARITY_EVEN/ODD - encodings of the parity_type input
//   calc_parity    - parity bit for a zero-extended data word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest word the parity helper handles; callers zero-extend, which
  // leaves the XOR reduction unchanged for any narrower DATA_WIDTH.
  localparam int MAX_DATA_WIDTH = 16;

  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      parity_type);
    return (parity_type == PARITY_EVEN) ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO feeding the UART transmitter.
//   clk, reset    - clock, synchronous active-low reset (flushes contents)
//   push_en/data  - write request; dropped when full
//   pop_en        - consume head entry (ignored when empty)
//   pop_data      - head entry, valid while !empty
//   full/empty    - occupancy flags decoded from the registered level
//   level         - entry count 0..FIFO_DEPTH
//   overflow      - one-cycle pulse after a write was dropped
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_en,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop_en,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full is judged on the registered level, so a pop in the same cycle
  // does not rescue a write that arrives while full.
  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push_en && !full;
  assign do_pop   = pop_en && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_en && full;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_transmitter.sv
// uart_buffered_transmitter: FIFO-buffered UART TX with internal baud counter.
//   clk, reset        - clock, synchronous active-low reset
//   parity_type       - 0 even, 1 odd (latched per frame)
//   parity_enable     - append parity bit (latched per frame)
//   two_stop_bits     - 1 or 2 stop bits (latched per frame)
//   prescale          - clk cycles per bit, 0/1 both mean 1 (latched per frame)
//   write_enable/data - push a word into the TX FIFO
//   fifo_full/empty/level, overflow - FIFO status
//   serial_data_out   - registered UART line, idle high
//   busy              - frame in progress (state != IDLE)
module uart_buffered_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        parity_type,
  input  logic                        parity_enable,
  input  logic                        two_stop_bits,
  input  logic [PRESCALE_WIDTH-1:0]   prescale,
  input  logic                        write_enable,
  input  logic [DATA_WIDTH-1:0]       write_data,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        serial_data_out,
  output logic                        busy
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  uart_state_t               state_q, state_d;
  logic                      pop;
  logic [DATA_WIDTH-1:0]     head_data;
  logic [MAX_DATA_WIDTH-1:0] head_ext;
  logic [PW-1:0]             eff_presc;

  logic [PW-1:0]             cnt_q;
  logic [PW-1:0]             presc_q;
  logic [DATA_WIDTH-1:0]     sh_q;
  logic [BW-1:0]             bit_idx_q;
  logic                      par_q;
  logic                      par_en_q;
  logic                      two_stop_q;
  logic                      stop_idx_q;
  logic                      line_d;
  logic                      bit_done;
  logic                      last_bit;
  logic                      stop_last;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_en   (write_enable),
    .push_data (write_data),
    .pop_en    (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .overflow  (overflow)
  );

  assign head_ext  = {{(MAX_DATA_WIDTH-DATA_WIDTH){1'b0}}, head_data};
  assign eff_presc = (prescale > PW'(1)) ? prescale : PW'(1);

  // presc_q is at least 1 whenever a frame is active, so the -1 never wraps
  // in a state where bit_done is used.
  assign bit_done  = (cnt_q == presc_q - 1'b1);
  assign last_bit  = (bit_idx_q == BW'(DATA_WIDTH - 1));
  assign stop_last = (stop_idx_q == two_stop_q);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:  if (bit_done) state_d = DATA;
      DATA:   if (bit_done && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_done) state_d = STOP;
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_done && stop_last) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the next cycle, so serial_data_out can be a plain flop.
  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      START:  line_d = 1'b0;
      DATA:   line_d = (state_q == DATA && bit_done) ? sh_q[1] : sh_q[0];
      PARITY: line_d = par_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      serial_data_out <= 1'b1;
      cnt_q           <= '0;
      presc_q         <= PW'(1);
      sh_q            <= '0;
      bit_idx_q       <= '0;
      par_q           <= 1'b0;
      par_en_q        <= 1'b0;
      two_stop_q      <= 1'b0;
      stop_idx_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      serial_data_out <= line_d;
      if (pop) begin
        // Frame configuration is frozen here; later input changes wait
        // for the next pop.
        sh_q       <= head_data;
        par_q      <= calc_parity(head_ext, parity_type);
        par_en_q   <= parity_enable;
        two_stop_q <= two_stop_bits;
        presc_q    <= eff_presc;
        cnt_q      <= '0;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
      end else if (state_q != IDLE) begin
        if (bit_done) begin
          cnt_q <= '0;
          if (state_q == DATA) begin
            sh_q      <= sh_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
          end
          if (state_q == STOP) stop_idx_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
module tb_uart_buffered_transmitter;

  localparam int DW = 8;
  localparam int FD = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          parity_type = 1'b0;
  logic          parity_enable = 1'b0;
  logic          two_stop_bits = 1'b0;
  logic [PW-1:0] prescale = 6'd4;
  logic          write_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          fifo_full, fifo_empty, overflow, serial_data_out, busy;
  logic [$clog2(FD):0] fifo_level;

  uart_buffered_transmitter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .parity_type     (parity_type),
    .parity_enable   (parity_enable),
    .two_stop_bits   (two_stop_bits),
    .prescale        (prescale),
    .write_enable    (write_enable),
    .write_data      (write_data),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .serial_data_out (serial_data_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            par_en;
    bit            par_bit;
    bit            two_stop;
    int            p;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input logic [DW-1:0] d, input bit pe, input bit pb,
                              input bit ts, input int p);
    frame_t f;
    f.data = d; f.par_en = pe; f.par_bit = pb; f.two_stop = ts; f.p = p;
    exp_q.push_back(f);
  endtask

  // Monitor: on each start bit pop the expected frame and check every cycle
  // of every bit (line value and busy) against the hand-given frame.
  logic   mon_active = 1'b0;
  logic   spurious = 1'b0;
  frame_t cur;
  logic   exp_bits [16];
  int     nbits, bi, ci;
  logic   bit_ok, bad_line, bad_busy;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      spurious   = 1'b0;
    end else begin
      if (!mon_active && !spurious && serial_data_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: line low at t=%0t, expected idle high", $time);
          spurious = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          nbits = 0;
          exp_bits[nbits++] = 1'b0;
          for (int i = 0; i < DW; i++) exp_bits[nbits++] = cur.data[i];
          if (cur.par_en) exp_bits[nbits++] = cur.par_bit;
          exp_bits[nbits++] = 1'b1;
          if (cur.two_stop) exp_bits[nbits++] = 1'b1;
          mon_active = 1'b1;
          bi = 0; ci = 0; bit_ok = 1'b1;
        end
      end
      if (spurious && serial_data_out === 1'b1) spurious = 1'b0;
      if (mon_active) begin
        if (serial_data_out !== exp_bits[bi] || busy !== 1'b1) begin
          bit_ok = 1'b0; bad_line = serial_data_out; bad_busy = busy;
        end
        ci++;
        if (ci == cur.p) begin
          checks++;
          if (!bit_ok) begin
            errors++;
            $display("FAIL frame_bit: word %0h bit %0d got line=%0b busy=%0b, expected line=%0b busy=1",
                     cur.data, bi, bad_line, bad_busy, exp_bits[bi]);
          end
          ci = 0; bi++; bit_ok = 1'b1;
          if (bi == nbits) mon_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [DW-1:0] d);
    write_data = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !mon_active && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, %0d frames outstanding, expected drained",
               name, budget, exp_q.size());
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic bz [44];
  logic ln [44];
  logic em [44];

  initial begin
    int fb, nb, lows;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_line", serial_data_out, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    tick();
    reset = 1'b1;
    tick();

    // Test 1: 0xA5, prescale 4, no parity, one stop
    prescale = 6'd4; parity_enable = 0; two_stop_bits = 0;
    write_data = 8'hA5; write_enable = 1'b1;
    expect_frame(8'hA5, 0, 0, 0, 4);
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      bz[c] = busy; ln[c] = serial_data_out; em[c] = fifo_empty;
      if (c == 1) write_enable = 1'b0;
    end
    fb = -1; nb = 0;
    for (int c = 0; c < 44; c++) begin
      if (bz[c] === 1'b1) begin
        nb++;
        if (fb < 0) fb = c;
      end
    end
    check("t1_empty_c0", em[0], 1);
    check("t1_empty_c1", em[1], 0);
    check("t1_line_c1", ln[1], 1);
    check("t1_line_c2", ln[2], 0);
    check("t1_busy_first", fb, 2);
    check("t1_busy_count", nb, 40);
    check("t1_busy_c41", bz[41], 1);
    check("t1_busy_c42", bz[42], 0);
    tick();
    wait_idle("t1_drain", 100);

    // Test 2: parity, prescale 1 (and 0 treated as 1)
    prescale = 6'd1; parity_enable = 1; parity_type = 0;
    expect_frame(8'h03, 1, 0, 0, 1);
    write_one(8'h03);
    wait_idle("t2_even", 50);
    parity_type = 1;
    expect_frame(8'h03, 1, 1, 0, 1);
    write_one(8'h03);
    wait_idle("t2_odd", 50);
    prescale = 6'd0;
    expect_frame(8'h80, 1, 0, 0, 1);
    write_one(8'h80);
    wait_idle("t2_presc0", 50);

    // Test 3: two stop bits, back-to-back frames, no gap
    prescale = 6'd2; parity_enable = 0; two_stop_bits = 1;
    write_data = 8'h81; write_enable = 1'b1;
    expect_frame(8'h81, 0, 0, 1, 2);
    tick();
    write_data = 8'h3C;
    expect_frame(8'h3C, 0, 0, 1, 2);
    tick();
    write_enable = 1'b0;
    nb = 0;
    for (int c = 2; c < 46; c++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    check("t3_busy_cont", nb, 44);
    @(negedge clk);
    check("t3_busy_end", busy, 0);
    tick();
    wait_idle("t3_drain", 50);
    two_stop_bits = 0;

    // Test 4: overflow with FIFO_DEPTH 8, prescale 63
    prescale = 6'd63;
    for (int k = 0; k < 10; k++) begin
      write_data = 8'h10 + 8'(k);
      write_enable = 1'b1;
      if (k < 9) expect_frame(8'h10 + 8'(k), 0, 0, 0, 63);
      @(negedge clk);
      if (k == 8) check("t4_full_c8", fifo_full, 0);
      if (k == 9) begin
        check("t4_full_c9", fifo_full, 1);
        check("t4_level_c9", fifo_level, 8);
        check("t4_ovf_c9", overflow, 0);
      end
      tick();
    end
    write_enable = 1'b0;
    @(negedge clk);
    check("t4_ovf_c10", overflow, 1);
    tick();
    @(negedge clk);
    check("t4_ovf_c11", overflow, 0);
    tick();
    wait_idle("t4_drain", 8000);

    // Test 5: parity_enable toggled during DATA of frame 1
    prescale = 6'd2; parity_type = 1; parity_enable = 0;
    expect_frame(8'h5A, 0, 0, 0, 2);
    write_data = 8'h5A; write_enable = 1'b1;
    tick();
    expect_frame(8'h0F, 1, 1, 0, 2);
    write_data = 8'h0F;
    tick();
    write_enable = 1'b0;
    repeat (6) tick();
    parity_enable = 1;
    wait_idle("t5_drain", 100);
    parity_enable = 0;

    // Test 6: reset during DATA flushes everything
    prescale = 6'd4;
    expect_frame(8'h3C, 0, 0, 0, 4);
    write_data = 8'h3C; write_enable = 1'b1;
    tick();
    write_data = 8'hC3;
    tick();
    write_enable = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("t6_line", serial_data_out, 1);
    check("t6_busy", busy, 0);
    check("t6_level", fifo_level, 0);
    check("t6_empty", fifo_empty, 1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    lows = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (serial_data_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t6_quiet", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_buffered_transmitter.md
Name: uart_buffered_transmitter

Overview:
Next-generation UART transmit path for the UART subsystem. It adds a parametrised TX FIFO, an internal prescale-driven baud generator, runtime-selectable 1 or 2 stop bits, and overflow reporting. One clock domain. Host logic pushes words; the block serialises them back-to-back as frames on serial_data_out.

Parameters:
DATA_WIDTH, 8, bits per data word (5..9 supported).
FIFO_DEPTH, 8, TX FIFO entries; power of 2, >= 2.
PRESCALE_WIDTH, 6, width of prescale input.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
parity_type  input  1  0 = even, 1 = odd.
parity_enable  input  1  1 = append parity bit.
two_stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
prescale  input  PRESCALE_WIDTH  clk cycles per bit; 0 and 1 both mean 1.
write_enable  input  1  push write_data into FIFO.
write_data  input  DATA_WIDTH  word to transmit.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
overflow  output  1  one-cycle pulse when a write is dropped.
serial_data_out  output  1  UART line, idle high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset==0 at clk edge):
  - serial_data_out=1, busy=0, fifo_empty=1, fifo_full=0, fifo_level=0, overflow=0.
  - FSM=IDLE, baud counter=0.
- Reset asserted mid-frame: line returns high on the next cycle, the frame is abandoned, and the FIFO is flushed.
- FIFO write:
  - A write is accepted iff write_enable && !fifo_full (registered flag).
  - A write while full is dropped and overflow=1 for exactly that following cycle. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if !fifo_empty, pop the head word and latch word, parity_type, parity_enable, two_stop_bits and effective prescale → START.
  - Config inputs changed mid-frame take effect from the next frame only.
  - START: line 0 for one bit period → DATA.
  - DATA: DATA_WIDTH bits, LSB first, one bit period each → PARITY if parity_enable, else STOP.
  - PARITY: even: bit = XOR of data; odd: bit = inverted XOR → STOP.
  - STOP: line 1 for 1 or 2 bit periods.
  - At the end of STOP: if !fifo_empty, pop and go directly to START (zero idle cycles between frames); else → IDLE.
- Bit period: exactly max(prescale,1) clk cycles. The baud counter restarts at each state entry.
- serial_data_out is registered and glitch-free. It is 1 in IDLE.
- busy=1 in every state except IDLE. It deasserts in the cycle the line enters IDLE.
- Latency: a write accepted at edge n makes fifo_empty=0 in cycle n+1. The FSM pops at edge n+1. Start bit is driven from cycle n+2.
- Frame length: 1 + DATA_WIDTH + parity_enable + (two_stop_bits ? 2 : 1) bit periods.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - PARITY_EVEN/PARITY_ODD constants;
  - a parity function parameterised on width.
- One sub-module, uart_sync_fifo (DATA_WIDTH, FIFO_DEPTH). It provides push/pop, full/empty/level, and a drop-on-full overflow pulse.
- Baud counter and FSM live in the top module.

Test Plan:
1. Basic frame: prescale=4, no parity, 1 stop, write 0xA5 at cycle 0 → line from cycle 2 reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide. busy high cycles 2–41.
2. Parity: prescale=1, parity_enable=1. Write 0x03 with even parity → parity bit 0. Same word with odd parity → parity bit 1. Frame is 11 cycles.
3. Two stop bits: prescale=2, two_stop_bits=1, two back-to-back writes → stop high for 4 cycles, then the next start bit with no idle gap. busy never drops between frames.
4. Overflow: FIFO_DEPTH=8, prescale=63, write 10 words in consecutive cycles →
   - 9 words accepted;
   - fifo_full=1 at cycle 9;
   - the 10th write dropped, overflow pulses once at cycle 10;
   - 9 frames are emitted in order.
5. Config change mid-frame: toggle parity_enable during the DATA state → the current frame is unchanged; the next frame uses the new setting.
6. Reset mid-frame: assert reset during the DATA state → next cycle the line reads 1, busy=0, fifo_level=0, and no further frames are sent.
